// File: rtl/fb_pc_fetch_ctrl_pkg.sv
// Shared types and constants for the IF-stage PC fetch controller.
package fb_pc_fetch_ctrl_pkg;

    localparam int          FB_32BITS   = 32;
    localparam logic [31:0] FB_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FB_PCF_BOOT      = 2'd0,
        FB_PCF_RUN       = 2'd1,
        FB_PCF_JALR_WAIT = 2'd2
    } pcf_state_e;

endpackage

// File: rtl/fb_pc_fetch_ctrl_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module fb_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: step only when requested and not already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/fb_pc_fetch_ctrl.sv
// IF-stage PC owner: next-PC selection, jalr lock handshake, IF/ID control
// and event counters.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   BOOT       | first cycle after reset; PC held so imem gets a read cycle
//   RUN        | normal fetch
//   JALR_WAIT  | jalr parked in ID; waiting for its target on predict_pc
module fb_pc_fetch_ctrl
    import fb_pc_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = FB_RESET_PC,
    parameter int          CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 pc_src,
    input  logic [31:0]          predict_pc,
    input  logic                 address_src,
    input  logic [31:0]          predict_err_pc,
    input  logic                 register_rst,
    input  logic                 lock,
    output logic [31:0]          pc,
    output logic                 jalr_en,
    output logic                 if_id_we,
    output logic                 if_id_bubble,
    output logic [CNT_WIDTH-1:0] mispredict_cnt,
    output logic [CNT_WIDTH-1:0] jalr_lock_cnt
);

    pcf_state_e            state_q, state_d;
    logic [FB_32BITS-1:0]  pc_q, pc_d;
    logic                  jalr_en_q, jalr_en_d;
    logic                  mispredict_inc;
    logic                  jalr_lock_inc;

    // Next state, priority next-PC mux and IF/ID controls.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        if_id_we       = 1'b0;
        if_id_bubble   = 1'b0;
        mispredict_inc = 1'b0;
        jalr_lock_inc  = 1'b0;
        case (state_q)
            FB_PCF_BOOT: begin
                state_d      = FB_PCF_RUN;
                if_id_bubble = 1'b1;
            end
            FB_PCF_RUN, FB_PCF_JALR_WAIT: begin
                if (address_src) begin
                    // Correction wins over stall and lock; wrong-path inst squashed.
                    pc_d           = predict_err_pc;
                    state_d        = FB_PCF_RUN;
                    if_id_we       = 1'b1;
                    if_id_bubble   = 1'b1;
                    mispredict_inc = 1'b1;
                end else if (stall) begin
                    state_d = state_q;
                end else if ((state_q == FB_PCF_RUN) && lock) begin
                    // Load the jalr into ID once, then bubble while it waits.
                    state_d       = FB_PCF_JALR_WAIT;
                    if_id_we      = 1'b1;
                    if_id_bubble  = 1'b1;
                    jalr_lock_inc = 1'b1;
                end else if (state_q == FB_PCF_JALR_WAIT) begin
                    // pc_src=0 here is a protocol error; fall through sequentially.
                    pc_d     = pc_src ? predict_pc : pc_q + 32'd1;
                    state_d  = FB_PCF_RUN;
                    if_id_we = 1'b1;
                end else begin
                    pc_d     = pc_src ? predict_pc : pc_q + 32'd1;
                    if_id_we = 1'b1;
                end
            end
            default: begin
                state_d      = FB_PCF_BOOT;
                if_id_bubble = 1'b1;
            end
        endcase
        jalr_en_d = (state_d == FB_PCF_JALR_WAIT);
    end

    // State, PC and jalr_en registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FB_PCF_BOOT;
            pc_q      <= RESET_PC;
            jalr_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            jalr_en_q <= jalr_en_d;
        end
    end

    fb_sat_counter #(.W(CNT_WIDTH)) u_mispredict_cnt (
        .clk (clk),
        .rst (rst),
        .inc (mispredict_inc),
        .cnt (mispredict_cnt)
    );

    fb_sat_counter #(.W(CNT_WIDTH)) u_jalr_lock_cnt (
        .clk (clk),
        .rst (rst),
        .inc (jalr_lock_inc),
        .cnt (jalr_lock_cnt)
    );

    assign pc      = pc_q;
    assign jalr_en = jalr_en_q;

    // The hazard unit raises flush and correction together.
    a_flush_matches_redirect: assert property (
        @(posedge clk) disable iff (rst) (register_rst == address_src)
    );

endmodule

// File: tb/tb_fb_pc_fetch_ctrl.sv
// Bench for fb_pc_fetch_ctrl: directed scenarios plus randomized traffic,
// checked against a behavioural model of the fetch rules.
module tb_fb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, pc_src, address_src, register_rst, lock;
    logic [31:0] predict_pc, predict_err_pc;

    logic [31:0] pc_a, pc_b;
    logic        jalr_en_a, jalr_en_b;
    logic        we_a, we_b, bub_a, bub_b;
    logic [15:0] mis_a, lck_a;
    logic [1:0]  mis_b, lck_b;

    int n_cmp = 0;
    int n_err = 0;

    // Model state
    logic [31:0] m_pc;
    bit          m_boot, m_wait;
    int          m_mis, m_lck;
    bit          e_we, e_bub;

    always #5 clk = ~clk;

    fb_pc_fetch_ctrl #(.RESET_PC(32'h0), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .stall(stall), .pc_src(pc_src), .predict_pc(predict_pc),
        .address_src(address_src), .predict_err_pc(predict_err_pc),
        .register_rst(register_rst), .lock(lock), .pc(pc_a), .jalr_en(jalr_en_a),
        .if_id_we(we_a), .if_id_bubble(bub_a), .mispredict_cnt(mis_a), .jalr_lock_cnt(lck_a)
    );

    fb_pc_fetch_ctrl #(.RESET_PC(32'h0), .CNT_WIDTH(2)) dut_w2 (
        .clk(clk), .rst(rst), .stall(stall), .pc_src(pc_src), .predict_pc(predict_pc),
        .address_src(address_src), .predict_err_pc(predict_err_pc),
        .register_rst(register_rst), .lock(lock), .pc(pc_b), .jalr_en(jalr_en_b),
        .if_id_we(we_b), .if_id_bubble(bub_b), .mispredict_cnt(mis_b), .jalr_lock_cnt(lck_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int top;
        top = (1 << w) - 1;
        return (v > top) ? top : v;
    endfunction

    task automatic chk_regs();
        chk("pc", pc_a, m_pc);
        chk("jalr_en", {31'b0, jalr_en_a}, {31'b0, m_wait});
        chk("mis_cnt", {16'b0, mis_a}, sat(m_mis, 16));
        chk("lock_cnt", {16'b0, lck_a}, sat(m_lck, 16));
        chk("w2_pc", pc_b, m_pc);
        chk("w2_jalr_en", {31'b0, jalr_en_b}, {31'b0, m_wait});
        chk("w2_mis_cnt", {30'b0, mis_b}, sat(m_mis, 2));
        chk("w2_lock_cnt", {30'b0, lck_b}, sat(m_lck, 2));
    endtask

    task automatic model_reset();
        m_pc   = 32'h0;
        m_boot = 1'b1;
        m_wait = 1'b0;
        m_mis  = 0;
        m_lck  = 0;
    endtask

    // One clock: apply inputs, check comb outputs, clock, advance model, check registers.
    task automatic cycle(input bit s, input bit ps, input logic [31:0] ppc,
                         input bit as, input logic [31:0] epc, input bit lk);
        logic [31:0] n_pc;
        bit          n_wait;
        stall = s; pc_src = ps; predict_pc = ppc;
        address_src = as; register_rst = as; predict_err_pc = epc; lock = lk;
        n_pc = m_pc; n_wait = m_wait;
        if (m_boot) begin
            e_we = 0; e_bub = 1;
        end else if (as) begin
            n_pc = epc; n_wait = 0; e_we = 1; e_bub = 1; m_mis++;
        end else if (s) begin
            e_we = 0; e_bub = 0;
        end else if (!m_wait && lk) begin
            n_wait = 1; e_we = 1; e_bub = 1; m_lck++;
        end else begin
            n_pc = ps ? ppc : m_pc + 32'd1;
            n_wait = 0; e_we = 1; e_bub = 0;
        end
        #1;
        chk("if_id_we", {31'b0, we_a}, {31'b0, e_we});
        chk("if_id_bubble", {31'b0, bub_a}, {31'b0, e_bub});
        chk("w2_if_id_we", {31'b0, we_b}, {31'b0, e_we});
        chk("w2_if_id_bubble", {31'b0, bub_b}, {31'b0, e_bub});
        @(posedge clk);
        m_pc = n_pc; m_wait = n_wait; m_boot = 0;
        #1;
        chk_regs();
    endtask

    task automatic idle();
        cycle(0, 0, 32'h0, 0, 32'h0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stall = 0; pc_src = 0; predict_pc = 0; address_src = 0;
        register_rst = 0; predict_err_pc = 0; lock = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", pc_a, 32'h0);
        chk("rst_jalr_en", {31'b0, jalr_en_a}, 32'h0);
        chk("rst_mis_cnt", {16'b0, mis_a}, 32'h0);
        chk("rst_lock_cnt", {16'b0, lck_a}, 32'h0);
        chk("rst_if_id_we", {31'b0, we_a}, 32'h0);
        chk("rst_if_id_bubble", {31'b0, bub_a}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int mis0;
        rst = 1'b1;
        do_reset();

        // Boot: pc sits at 0 through BOOT and the first RUN cycle, then counts.
        idle(); chk("boot_pc0", pc_a, 32'h0);
        idle(); chk("boot_pc1", pc_a, 32'h1);
        idle(); chk("boot_pc2", pc_a, 32'h2);
        idle(); chk("boot_pc3", pc_a, 32'h3);

        // Taken prediction from pc=10.
        cycle(0, 0, 0, 1, 32'd10, 0);
        mis0 = m_mis;
        cycle(0, 1, 32'd4, 0, 0, 0);
        chk("pred_pc", pc_a, 32'd4);
        chk("pred_mis_unchanged", {16'b0, mis_a}, mis0);

        // jalr lock at pc=20, then target arrives.
        cycle(0, 0, 0, 1, 32'd20, 0);
        cycle(0, 0, 0, 0, 0, 1);
        chk("lock_pc_hold", pc_a, 32'd20);
        chk("lock_jalr_en", {31'b0, jalr_en_a}, 32'h1);
        chk("lock_cnt_1", {16'b0, lck_a}, 32'h1);
        cycle(0, 1, 32'h40, 0, 0, 0);
        chk("jalr_target", pc_a, 32'h40);
        chk("jalr_en_clear", {31'b0, jalr_en_a}, 32'h0);

        // Correction while in JALR_WAIT.
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 1, 32'd7, 1);
        chk("wait_redirect_pc", pc_a, 32'd7);
        chk("wait_redirect_jalr_en", {31'b0, jalr_en_a}, 32'h0);

        // Stall holds; correction overrides stall.
        cycle(0, 0, 0, 1, 32'd5, 0);
        repeat (3) begin
            cycle(1, 1, 32'h99, 0, 0, 1);
            chk("stall_pc", pc_a, 32'd5);
        end
        cycle(1, 0, 0, 1, 32'd9, 0);
        chk("stall_redirect_pc", pc_a, 32'd9);

        // Stall inside JALR_WAIT keeps jalr_en up; protocol-error exit takes pc+1.
        cycle(0, 0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0, 0);
        chk("wait_stall_jalr_en", {31'b0, jalr_en_a}, 32'h1);
        cycle(0, 0, 32'h123, 0, 0, 0);
        chk("wait_nopcsrc_pc", pc_a, 32'd10);

        // PC wraps.
        cycle(0, 0, 0, 1, 32'hFFFF_FFFF, 0);
        idle();
        chk("wrap_pc", pc_a, 32'h0);
        chk("w2_mis_saturated", {30'b0, mis_b}, 32'h3);

        // Asynchronous reset in JALR_WAIT.
        cycle(0, 0, 0, 1, 32'h55, 0);
        cycle(0, 0, 0, 0, 0, 1);
        rst = 1'b1;
        #1;
        chk("async_rst_pc", pc_a, 32'h0);
        chk("async_rst_jalr_en", {31'b0, jalr_en_a}, 32'h0);
        do_reset();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit s, ps, as, lk;
            as = ($urandom_range(0, 9) == 0);
            s  = ($urandom_range(0, 5) == 0);
            lk = ($urandom_range(0, 7) == 0);
            ps = m_wait ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
            if (m_boot) begin
                as = 0;
            end
            cycle(s, ps, $urandom, as, $urandom, lk);
            if (i == 1500) begin
                do_reset();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
